// File: rtl/spart_pkg.sv
// spart_pkg: shared definitions for the SPART receive path.
//   rxState_e        - receiver FSM states
//   SPART_OVERSAMPLE - ticks per bit time
//   VOTE_SAMPLE_*    - sub-bit indices sampled for the majority vote
//   SC_LAST          - last sub-bit index of a bit time
//   DEFAULT_DIVISOR  - default tick reload value
//   majority3()      - 2-of-3 majority helper
// Optional feature macro: SPART_RX_PARITY_EN (the PARITY state is only reached
// when it is defined).
package spart_pkg;

  localparam int SPART_OVERSAMPLE = 16;
  localparam int DEFAULT_DIVISOR  = 122;

  localparam logic [3:0] VOTE_SAMPLE_A = 4'd7;
  localparam logic [3:0] VOTE_SAMPLE_B = 4'd8;
  localparam logic [3:0] VOTE_SAMPLE_C = 4'd9;
  localparam logic [3:0] SC_LAST       = 4'(SPART_OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/read_baud_generator.sv
// read_baud_generator: free-running oversample tick source for the receiver.
//   DIVISOR   - reload value; one tick every DIVISOR+1 clocks
//   clk, rst  - clock, asynchronous active-high reset
//   tick      - high for the single clock in which the counter is 0
module read_baud_generator
  import spart_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= 16'(DIVISOR);
    else if (count == 16'd0) count <= 16'(DIVISOR);
    else                    count <= count - 16'd1;
  end

  assign tick = (count == 16'd0);

endmodule

// File: rtl/spart_rx.sv
// spart_rx: SPART receiver. Oversamples rxd 16x, qualifies start bits,
// recovers LSB-first frames with 2-of-3 majority voting and holds each
// completed byte until read.
//   clk, rst   - clock, asynchronous active-high reset
//   rxd        - asynchronous serial input, idles high
//   rd         - single-cycle consume strobe
//   data       - last received byte
//   rda        - receive data available
//   frame_err  - stop bit of the last loaded frame sampled 0
//   overrun    - last load overwrote unread data
//   parity_err - even-parity error of the last frame (SPART_RX_PARITY_EN only)
// Optional feature macro: SPART_RX_PARITY_EN adds a parity bit after the data.
module spart_rx
  import spart_pkg::*;
#(
  parameter int DIVISOR   = DEFAULT_DIVISOR,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
`ifdef SPART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

  logic                 rxMeta, rxs, tick;
  rxState_e             state, stateNext;
  logic [3:0]           sc, scNext;
  logic [BC_W-1:0]      bc, bcNext;
  logic [DATA_BITS-1:0] shiftReg, shiftNext;
  logic                 sampleA, sampleB, vote;
  logic                 voteTick, endTick, loadFrame;
`ifdef SPART_RX_PARITY_EN
  logic                 parityBit, parityNext;
`endif

  // Two-flop synchronizer; resets to the idle level so reset never looks
  // like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= rxd;
      rxs    <= rxMeta;
    end
  end

  read_baud_generator #(.DIVISOR(DIVISOR)) baudGen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // The first two vote samples are stored; the third is the live rxs at the
  // voting tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sampleA <= 1'b1;
      sampleB <= 1'b1;
    end else begin
      if (tick && sc == VOTE_SAMPLE_A) sampleA <= rxs;
      if (tick && sc == VOTE_SAMPLE_B) sampleB <= rxs;
    end
  end

  assign vote     = majority3(sampleA, sampleB, rxs);
  assign voteTick = tick && (sc == VOTE_SAMPLE_C);
  assign endTick  = tick && (sc == SC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sc       <= '0;
      bc       <= '0;
      shiftReg <= '0;
`ifdef SPART_RX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      sc       <= scNext;
      bc       <= bcNext;
      shiftReg <= shiftNext;
`ifdef SPART_RX_PARITY_EN
      parityBit <= parityNext;
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    scNext    = sc;
    bcNext    = bc;
    shiftNext = shiftReg;
    loadFrame = 1'b0;
`ifdef SPART_RX_PARITY_EN
    parityNext = parityBit;
`endif
    if (tick) scNext = sc + 4'd1;

    case (state)
      IDLE: begin
        if (tick && !rxs) begin
          scNext    = '0;
          stateNext = START;
        end
      end
      START: begin
        if (voteTick && vote) begin
          stateNext = IDLE;                // false start: line back high
        end else if (endTick) begin
          bcNext    = '0;
          stateNext = DATA;
        end
      end
      DATA: begin
        if (voteTick) shiftNext = {vote, shiftReg[DATA_BITS-1:1]};
        if (endTick) begin
          bcNext = bc + 1'b1;
`ifdef SPART_RX_PARITY_EN
          if (bc == LAST_BIT) stateNext = PARITY;
`else
          if (bc == LAST_BIT) stateNext = STOP;
`endif
        end
      end
`ifdef SPART_RX_PARITY_EN
      PARITY: begin
        if (voteTick) parityNext = vote;
        if (endTick)  stateNext  = STOP;
      end
`endif
      STOP: begin
        // Leave at the vote rather than at sc=15 so an early next start bit
        // is still caught.
        if (voteTick) begin
          loadFrame = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output register: a load always wins over a concurrent rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (loadFrame) begin
      data      <= shiftReg;
      rda       <= 1'b1;
      frame_err <= ~vote;
      overrun   <= rda & ~rd;
`ifdef SPART_RX_PARITY_EN
      parity_err <= (^shiftReg) ^ parityBit;
`endif
    end else if (rd && rda) begin
      rda <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: scoreboard bench for spart_rx. Stimulus pushes the expected
// load for each frame; a monitor pops and compares whenever the DUT loads.
// Honours SPART_RX_PARITY_EN to match the DUT build.
module tb_spart_rx;

  localparam int DIVISOR   = 3;
  localparam int TICK_CLKS = DIVISOR + 1;
  localparam int BIT_CLKS  = 16 * TICK_CLKS;
`ifdef SPART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       frameErr;
    logic       overrun;
    logic       parityErr;
  } expect_t;

  logic       clk, rst, rxd, rd;
  logic [7:0] data;
  logic       rda, frame_err, overrun;
`ifdef SPART_RX_PARITY_EN
  logic       parity_err;
`endif

  int      tests = 0;
  int      fails = 0;
  int      cyc;
  expect_t sb[$];

  spart_rx #(.DIVISOR(DIVISOR), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rd       (rd),
    .data     (data),
    .rda      (rda),
    .frame_err(frame_err),
    .overrun  (overrun)
`ifdef SPART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; the DUT ticks on multiples of TICK_CLKS.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectLoad(input logic [7:0] d, input logic fe, input logic ov, input logic pe);
    expect_t e;
    e.data = d; e.frameErr = fe; e.overrun = ov; e.parityErr = pe;
    sb.push_back(e);
  endtask

  // Monitor: a load shows up as rda rising, or as new contents while rda is held.
  initial begin
    logic       rdaPrev, fePrev, ovPrev;
    logic [7:0] dataPrev;
    expect_t    e;
    rdaPrev = 0; fePrev = 0; ovPrev = 0; dataPrev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdaPrev = 0; fePrev = 0; ovPrev = 0; dataPrev = 0;
      end else begin
        if (rda && (!rdaPrev || data != dataPrev || frame_err != fePrev || overrun != ovPrev)) begin
          check("load_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_data", data, e.data);
            check("sb_frame_err", frame_err, e.frameErr);
            check("sb_overrun", overrun, e.overrun);
`ifdef SPART_RX_PARITY_EN
            check("sb_parity_err", parity_err, e.parityErr);
`endif
          end
        end
        rdaPrev = rda; fePrev = frame_err; ovPrev = overrun; dataPrev = data;
      end
    end
  end

  // Return at a negedge such that a falling rxd edge driven now is seen by
  // the FSM exactly on a tick (2 synchronizer clocks later).
  task automatic alignStart();
    do @(negedge clk); while ((cyc % TICK_CLKS) != (TICK_CLKS - 3));
  endtask

  task automatic driveBit(input logic level, input int clks, input bit glitch);
    rxd = level;
    if (glitch) begin
      repeat (34) @(negedge clk);
      rxd = 1'b0;                        // one tick low over the sc=8 sample
      repeat (4) @(negedge clk);
      rxd = level;
      repeat (clks - 38) @(negedge clk);
    end else begin
      repeat (clks) @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [7:0] value, input logic stopBit, input logic parityBit,
                           input int bitClks, input int glitchBit, input bit rdAtLoad);
    int p, loadCyc;
    alignStart();
    p       = cyc + 1;
    loadCyc = p + 42 + BIT_CLKS * (9 + PAR);
    fork
      begin
        driveBit(1'b0, bitClks, glitchBit == 0);
        for (int i = 0; i < 8; i++) driveBit(value[i], bitClks, glitchBit == i + 1);
        if (PAR == 1) driveBit(parityBit, bitClks, 1'b0);
        driveBit(stopBit, bitClks, 1'b0);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
      end
      begin
        if (rdAtLoad) begin
          while (cyc != loadCyc - 1) @(negedge clk);
          rd = 1'b1;
          @(negedge clk);
          rd = 1'b0;
        end
      end
    join
  endtask

  task automatic readByte(input string name);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check(name, rda, 0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_data"}, data, 0);
    check({tag, "_rda"}, rda, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
`ifdef SPART_RX_PARITY_EN
    check({tag, "_parity_err"}, parity_err, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetValues("reset");

    // Ideal frame, then read.
    expectLoad(8'hA5, 0, 0, 0);
    sendFrame(8'hA5, 1, ^8'hA5, BIT_CLKS, -1, 0);
    check("a5_rda_set", rda, 1);
    readByte("a5_rd_clears_rda");
    check("a5_data_held_after_rd", data, 8'hA5);

    // Short glitch: false start, no load; then a real frame.
    alignStart();
    rxd = 1'b0;
    repeat (4 * TICK_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check("glitch_no_rda", rda, 0);
    expectLoad(8'h3C, 0, 0, 0);
    sendFrame(8'h3C, 1, ^8'h3C, BIT_CLKS, -1, 0);
    readByte("3c_rd");

    // Framing error, flag survives rd, cleared by next clean load.
    expectLoad(8'h3C, 1, 0, 0);
    sendFrame(8'h3C, 0, ^8'h3C, BIT_CLKS, -1, 0);
    readByte("fe_rd");
    check("fe_held_after_rd", frame_err, 1);
    expectLoad(8'h00, 0, 0, 0);
    sendFrame(8'h00, 1, 1'b0, BIT_CLKS, -1, 0);
    readByte("00_rd");

    // Overrun, then rd in the load clock.
    expectLoad(8'h11, 0, 0, 0);
    sendFrame(8'h11, 1, ^8'h11, BIT_CLKS, -1, 0);
    expectLoad(8'h22, 0, 1, 0);
    sendFrame(8'h22, 1, ^8'h22, BIT_CLKS, -1, 0);
    check("ov_held", overrun, 1);
    expectLoad(8'h33, 0, 0, 0);
    sendFrame(8'h33, 1, ^8'h33, BIT_CLKS, -1, 1);
    check("rd_in_load_rda_stays", rda, 1);
    readByte("33_rd");

    // Single-tick glitch on data bit 3, then +/-3% bit periods.
    expectLoad(8'hFF, 0, 0, 0);
    sendFrame(8'hFF, 1, ^8'hFF, BIT_CLKS, 4, 0);
    readByte("ff_rd");
    expectLoad(8'h96, 0, 0, 0);
    sendFrame(8'h96, 1, ^8'h96, BIT_CLKS - 2, -1, 0);
    readByte("fast_rd");
    expectLoad(8'h69, 0, 0, 0);
    sendFrame(8'h69, 1, ^8'h69, BIT_CLKS + 2, -1, 0);
    readByte("slow_rd");

    // Reset during data bit 4 with unread data pending.
    expectLoad(8'h81, 0, 0, 0);
    sendFrame(8'h81, 1, ^8'h81, BIT_CLKS, -1, 0);
    alignStart();
    driveBit(1'b0, BIT_CLKS, 0);
    driveBit(1'b1, BIT_CLKS, 0);
    driveBit(1'b0, BIT_CLKS, 0);
    driveBit(1'b1, BIT_CLKS, 0);
    driveBit(1'b0, BIT_CLKS, 0);
    rxd = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetValues("midreset");
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("midreset_no_load", rda, 0);
    expectLoad(8'h5A, 0, 0, 0);
    sendFrame(8'h5A, 1, ^8'h5A, BIT_CLKS, -1, 0);
    check("5a_data", data, 8'h5A);
    readByte("5a_rd");

`ifdef SPART_RX_PARITY_EN
    expectLoad(8'h07, 0, 0, 1);
    sendFrame(8'h07, 1, 1'b0, BIT_CLKS, -1, 0);
    check("parity_err_set", parity_err, 1);
`endif

    repeat (BIT_CLKS) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
# spart_rx

Receive half of the SPART serial port. The block oversamples the asynchronous `rxd` line at 16 ticks per bit, detects and qualifies start bits, and recovers LSB-first data frames using 3-sample majority voting. It presents each completed byte on a hold-until-read register with framing and overrun status. It is the counterpart of the transmit path: same tick period, same 16-tick bit time, same frame format. It sits between the pad synchronizer and the SPART bus interface.

## Interface
- `DIVISOR`, default 122: tick reload value; one tick every DIVISOR+1 clocks.
- `DATA_BITS`, default 8: data bits per frame.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `rxd` in 1: serial input; asynchronous; idles high.
- `rd` in 1: consume strobe from the bus side, single cycle.
- `data` out DATA_BITS: last received byte.
- `rda` out 1: receive data available.
- `frame_err` out 1: stop bit of the last loaded frame sampled 0.
- `overrun` out 1: last load overwrote unread data.
- `parity_err` out 1: present only with `SPART_RX_PARITY_EN`.

## Operation
- `rxd` passes through a 2-flop synchronizer that resets to 1. All logic uses the synchronized `rxs`.
- Tick generator:
  - A 16-bit down-counter reloads to DIVISOR at reset and whenever it reaches 0.
  - `tick` is asserted for the one clock in which the counter equals 0.
  - It is free-running and is never reset by the FSM.
- Sub-bit counter `sc` is 4 bits and advances on `tick`. Bit counter `bc` counts the bits already received.
- The FSM has states IDLE, START, DATA, (PARITY), STOP.
  - IDLE: on `tick` with `rxs`=0, set `sc`=0 and go to START.
  - All states: sample `rxs` on ticks with `sc`=7, 8 and 9. The vote is the 2-of-3 majority, evaluated at the `sc`=9 tick.
  - START: if the vote is 1 (false start), return to IDLE. Otherwise, at `sc`=15 go to DATA with `bc`=0.
  - DATA: at the vote, shift the vote into the MSB of the shift register, so the first bit received ends at bit 0. At `sc`=15, increment `bc`. When `bc` reaches DATA_BITS, go to PARITY (macro) or STOP.
  - PARITY: latch the vote. At `sc`=15, go to STOP.
  - STOP: at the vote, perform the load described below and go straight to IDLE. The FSM does not wait for `sc`=15, so it can resynchronise to an early next start bit.
- Load, in the same clock as the STOP vote:
  - `data` takes the shift register value and `rda` is set to 1.
  - `frame_err` takes the inverse of the vote.
  - `overrun` takes (`rda` & ~`rd`), evaluated in that clock.
  - The frame is loaded even when a framing error is flagged.
- `rd` with `rda`=1 clears `rda` on the next clock. `rd` with `rda`=0 has no effect.
- `rd` in the same clock as a load: the load wins, `rda` stays 1 and `overrun` is 0.
- Error flags hold until the next load; `rd` does not clear them.

## Timing
- Reset values: `data`=0, `rda`=0, `frame_err`=0, `overrun`=0, `parity_err`=0, FSM in IDLE, `rxs`=1.
- Bit time is 16×(DIVISOR+1) clocks; 1968 clocks at the default.
- Input latency: 2 clocks through the synchronizer.
- Start detection jitter: up to 1 tick (DIVISOR+1 clocks).
- `rda` rises 1 clock after the tick at which the STOP bit has `sc`=9.
- Reset mid-frame: the partial frame is discarded, all outputs return to their reset values, and the next falling edge is treated as a new start.

## Configuration
- `SPART_RX_PARITY_EN` defined:
  - A PARITY state follows the DATA bits and checks even parity.
  - At load, `parity_err` takes (XOR of the data bits XOR the parity vote). It holds until the next load.
- `SPART_RX_PARITY_EN` undefined:
  - No PARITY state and no `parity_err` port.
  - The frame is start + DATA_BITS + stop.

## Structure
- Package `spart_pkg` holds:
  - the FSM state typedef;
  - the `SPART_OVERSAMPLE`=16 constant;
  - the vote sample indices 7, 8 and 9;
  - the default DIVISOR (122).
- One sub-module, `read_baud_generator`, contains the tick counter (port DIVISOR; outputs `tick`). The FSM, synchronizer and output register stay in `spart_rx`.

## Test plan
- Ideal-timing frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop=1 → `data`=0xA5, `rda`=1, `frame_err`=0, `overrun`=0. Then `rd` → `rda`=0 on the next clock.
- `rxd` low for 4 ticks then high (glitch) → FSM returns to IDLE and `rda` stays 0. A following 0x3C frame → `data`=0x3C.
- Frame 0x3C with stop=0 → `data`=0x3C, `rda`=1, `frame_err`=1. A next clean frame 0x00 → `frame_err`=0.
- Two frames 0x11 then 0x22 with no `rd` → `data`=0x22, `overrun`=1. Repeat with `rd` in the load clock → `overrun`=0 and `rda`=1.
- A single-tick glitch at `sc`=8 of data bit 3 of 0xFF → majority keeps `data`=0xFF. Repeat with bit periods ±3% → byte still recovered correctly.
- Assert `rst` during data bit 4, release it, then send 0x5A → no load for the partial frame, outputs at reset values, then `data`=0x5A. With `SPART_RX_PARITY_EN`: 0x07 with parity bit 0 → `parity_err`=1.
